// File: rtl/disp_scan_sched_if.sv
// Frame update port of the display scan scheduler: a 64-bit frame offered
// under a valid/ready handshake.
interface disp_scan_sched_if;
  logic [63:0] seg_data_in;
  logic        upd_valid;
  logic        upd_ready;

  modport master (
    output seg_data_in,
    output upd_valid,
    input  upd_ready
  );

  modport slave (
    input  seg_data_in,
    input  upd_valid,
    output upd_ready
  );
endinterface

// File: rtl/disp_scan_sched.sv
// Eight-digit scan scheduler: blank guard + lit phase per digit, double-buffered frame
// committed only at frame end. Optional macro DISP_DIM_EN adds PWM dimming via dim.
module disp_scan_sched #(
  parameter int DIGIT_TICKS = 10000,
  parameter int BLANK_TICKS = 16
) (
  input  logic              clk_10Mhz,
  input  logic              reset,
`ifdef DISP_DIM_EN
  input  logic [3:0]        dim,
`endif
  disp_scan_sched_if.slave  upd,
  input  logic [7:0]        digit_en,
  output logic [63:0]       seg_data,
  output logic [7:0]        an_sel,
  output logic [2:0]        digit_idx,
  output logic              frame_done
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  generate
    if (BLANK_TICKS < 1 || DIGIT_TICKS < 1) begin : g_bad_params
      $error("disp_scan_sched: BLANK_TICKS and DIGIT_TICKS must both be >= 1");
    end
  endgenerate

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       an_sel_reg, an_sel_next;
  logic             frame_done_reg, frame_done_next;
  logic [63:0]      seg_data_reg;
  logic [63:0]      shadow_reg;
  logic             pending_reg;
  logic             lit_next;
  logic             upd_ready_int;
  logic             xfer;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_ONE;
    idx_next   = idx_reg;
    case (state_reg)
      ST_BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = ST_ON;
          cnt_next   = '0;
        end
      end
      default: begin
        if (cnt_reg == DIGIT_LAST) begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          idx_next   = idx_reg + 3'd1;
        end
      end
    endcase
  end

`ifdef DISP_DIM_EN
  logic [3:0] pwm_cnt_reg;
  logic [3:0] pwm_next;

  assign pwm_next = pwm_cnt_reg + 4'd1;
  assign lit_next = (state_next == ST_ON) && (pwm_next <= dim);

  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      pwm_cnt_reg <= 4'd0;
    end else begin
      pwm_cnt_reg <= pwm_next;
    end
  end
`else
  assign lit_next = (state_next == ST_ON);
`endif

  // an_sel is registered from the next-state view so it lines up with state_reg.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_an
      assign an_sel_next[gi] = ~(lit_next && (idx_next == 3'(gi)) && digit_en[gi]);
    end
  endgenerate

  assign frame_done_next = (state_next == ST_ON) && (cnt_next == DIGIT_LAST) &&
                           (idx_next == 3'd7);

  assign upd_ready_int = !pending_reg && !reset;
  assign xfer          = upd.upd_valid && upd_ready_int;

  always_ff @(posedge clk_10Mhz) begin
    if (reset) begin
      state_reg      <= ST_BLANK;
      cnt_reg        <= '0;
      idx_reg        <= 3'd0;
      an_sel_reg     <= 8'hFF;
      frame_done_reg <= 1'b0;
      seg_data_reg   <= '1;
      shadow_reg     <= '1;
      pending_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      an_sel_reg     <= an_sel_next;
      frame_done_reg <= frame_done_next;
      // A transfer needs an empty shadow, so it never coincides with a commit.
      if (xfer) begin
        shadow_reg  <= upd.seg_data_in;
        pending_reg <= 1'b1;
      end else if (frame_done_reg && pending_reg) begin
        seg_data_reg <= shadow_reg;
        pending_reg  <= 1'b0;
      end
    end
  end

  assign upd.upd_ready = upd_ready_int;
  assign seg_data      = seg_data_reg;
  assign an_sel        = an_sel_reg;
  assign digit_idx     = idx_reg;
  assign frame_done    = frame_done_reg;

endmodule
